uart_line_buffer: RTL and testbench

- Sits between the UART receiver and the UART transmitter in the serial echo path.
- Collects received bytes into a line, applying backspace editing as bytes arrive.
- On carriage return, replays the completed line to the transmitter byte by byte, respecting the transmitter's busy handshake.
- Gives line-at-a-time echo instead of raw per-byte loopback.

---
 rtl/uart_line_buffer.sv | 98 +++++++++
 tb/tb_uart_line_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: line-edited echo buffer between UART RX and TX; optional LF after CR via UART_LINE_BUFFER_CRLF_EN
module uart_line_buffer #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_we,
  input  logic          tx_busy,
  output logic          overflow,
  output logic          rx_dropped,
  output logic [AW:0]   line_len
);
  typedef enum logic {COLLECT, DRAIN} state_t;
  state_t      r_state;
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]  r_mem [DEPTH];
  logic [7:0]  r_tx_data;
  logic        r_tx_we, r_overflow, r_rx_dropped;
  logic        w_bs, w_cr, w_room, w_emit, w_empty, w_done, w_store;
`ifdef UART_LINE_BUFFER_CRLF_EN
  logic        r_lf;
`endif
  assign w_bs    = rx_data == 8'h08 || rx_data == 8'h7F;
  assign w_cr    = rx_data == 8'h0D;
  assign w_room  = r_wr_ptr < (AW+1)'(DEPTH - 1);
  assign w_emit  = !tx_busy && !r_tx_we;
  assign w_empty = r_rd_ptr == r_wr_ptr;
  assign w_store = r_state == COLLECT && rx_valid && !w_bs && (w_cr || w_room);
`ifdef UART_LINE_BUFFER_CRLF_EN
  assign w_done  = w_empty && r_lf;
`else
  assign w_done  = w_empty;
`endif
  assign tx_data    = r_tx_data;
  assign tx_we      = r_tx_we;
  assign overflow   = r_overflow;
  assign rx_dropped = r_rx_dropped;
  assign line_len   = r_state == DRAIN ? r_wr_ptr - r_rd_ptr : r_wr_ptr;
  // line storage, written in the same cycle as the accepted rx strobe
  always_ff @(posedge clk)
    if (w_store) r_mem[r_wr_ptr[AW-1:0]] <= rx_data;
  // collect/edit incoming bytes, then replay the line under the tx busy handshake
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state      <= COLLECT;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_tx_data    <= 8'h00;
      r_tx_we      <= 1'b0;
      r_overflow   <= 1'b0;
      r_rx_dropped <= 1'b0;
`ifdef UART_LINE_BUFFER_CRLF_EN
      r_lf         <= 1'b0;
`endif
    end else begin
      r_tx_we      <= 1'b0;
      r_rx_dropped <= 1'b0;
      if (r_state == COLLECT) begin
        if (rx_valid) begin
          if (w_bs) begin
            if (r_wr_ptr != '0) r_wr_ptr <= r_wr_ptr - 1'b1;
          end else if (w_cr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
            r_state  <= DRAIN;
          end else if (w_room) r_wr_ptr <= r_wr_ptr + 1'b1;
          else r_overflow <= 1'b1;
        end
      end else begin
        r_rx_dropped <= rx_valid;
        if (w_done) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_state  <= COLLECT;
`ifdef UART_LINE_BUFFER_CRLF_EN
          r_lf     <= 1'b0;
`endif
        end else if (w_emit) begin
          r_tx_we <= 1'b1;
`ifdef UART_LINE_BUFFER_CRLF_EN
          if (w_empty) begin
            r_tx_data <= 8'h0A;
            r_lf      <= 1'b1;
          end else begin
            r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
            r_rd_ptr  <= r_rd_ptr + 1'b1;
          end
`else
          r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
          r_rd_ptr  <= r_rd_ptr + 1'b1;
`endif
        end
      end
    end
endmodule

// File: tb/tb_uart_line_buffer.sv
// tb_uart_line_buffer: scoreboard bench for uart_line_buffer with a 10-cycle busy transmitter model
module tb_uart_line_buffer;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_we;
  logic          tx_busy;
  logic          overflow;
  logic          rx_dropped;
  logic [AW:0]   line_len;
  logic          force_busy = 1'b0;
  int            busy_cnt;
  int            errors = 0;
  int            checks = 0;
  int            strobes = 0;
  int            drop_cnt = 0;
  logic          prev_we = 1'b0;
  logic [7:0]    exp_q[$];
  logic [7:0]    line_q[$];
  logic          exp_ovf = 1'b0;
  logic [7:0]    exp_b;

  uart_line_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_we(tx_we), .tx_busy(tx_busy),
    .overflow(overflow), .rx_dropped(rx_dropped), .line_len(line_len)
  );

  always #5 clk = ~clk;

  // transmitter model: busy for 10 cycles after each write strobe
  always @(posedge clk or posedge reset)
    if (reset) busy_cnt <= 0;
    else if (tx_we) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  assign tx_busy = force_busy || busy_cnt != 0;

  // output monitor: pops the scoreboard on every strobe and checks the handshake
  always @(negedge clk) begin
    if (rx_dropped) drop_cnt++;
    if (tx_we) begin
      checks++;
      strobes++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe tx_data=%h required no strobe", tx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (tx_data !== exp_b) begin
          errors++;
          $display("FAIL tx_data got=%h required=%h", tx_data, exp_b);
        end
      end
      if (prev_we) begin
        errors++;
        $display("FAIL holdoff back_to_back tx_we got=1 required=0");
      end
      if (tx_busy) begin
        errors++;
        $display("FAIL strobe_while_busy tx_busy got=1 required=0");
      end
    end
    prev_we = tx_we;
  end

  // drive one byte in COLLECT and update the reference line model
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    if (b == 8'h08 || b == 8'h7F) begin
      if (line_q.size() > 0) void'(line_q.pop_back());
    end else if (b == 8'h0D) begin
      line_q.push_back(b);
      foreach (line_q[i]) exp_q.push_back(line_q[i]);
`ifdef UART_LINE_BUFFER_CRLF_EN
      exp_q.push_back(8'h0A);
`endif
      line_q.delete();
    end else if (line_q.size() < DEPTH - 1) line_q.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || line_len !== '0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 600) begin
      errors++;
      $display("FAIL %s drain_timeout pending=%0d required=0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (line_len !== '0) begin
      errors++;
      $display("FAIL %s line_len_after got=%0d required=0", name, line_len);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_we !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0 || rx_dropped !== 1'b0 || line_len !== '0) begin
      errors++;
      $display("FAIL reset_state got we=%b data=%h ovf=%b drop=%b len=%0d required 0/00/0/0/0",
               tx_we, tx_data, overflow, rx_dropped, line_len);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    send_byte("A");
    send_byte("B");
    checks++;
    if (line_len !== 3'd2) begin
      errors++;
      $display("FAIL basic_line_len got=%0d required=2", line_len);
    end
    send_byte(8'h0D);
    wait_drain("basic");
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL basic_overflow got=%b required=0", overflow);
    end
  endtask

  task automatic test_backspace;
    send_byte("A");
    send_byte("B");
    send_byte("C");
    send_byte(8'h08);
    checks++;
    if (line_len !== 3'd2) begin
      errors++;
      $display("FAIL backspace_line_len got=%0d required=2", line_len);
    end
    send_byte("D");
    send_byte(8'h0D);
    wait_drain("backspace");
  endtask

  task automatic test_empty;
    send_byte(8'h08);
    send_byte(8'h7F);
    checks++;
    if (line_len !== '0) begin
      errors++;
      $display("FAIL empty_underflow line_len got=%0d required=0", line_len);
    end
    send_byte(8'h0D);
    wait_drain("empty");
  endtask

  task automatic test_drop_busy;
    int s0, d0;
    force_busy = 1'b1;
    send_byte("H");
    send_byte("I");
    send_byte(8'h0D);
    s0 = strobes;
    d0 = drop_cnt;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_data = 8'h30 + 8'(i);
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (drop_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL drop_pulses got=%0d required=3", drop_cnt - d0);
    end
    checks++;
    if (strobes !== s0) begin
      errors++;
      $display("FAIL stall_no_strobe got=%0d required=%0d", strobes, s0);
    end
    checks++;
    if (line_len !== 3'd3) begin
      errors++;
      $display("FAIL stall_line_len got=%0d required=3", line_len);
    end
    force_busy = 1'b0;
    wait_drain("drop_busy");
  endtask

  task automatic test_overflow;
    send_byte("W");
    send_byte("X");
    send_byte("Y");
    send_byte("Z");
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL overflow_set got=%b required=%b", overflow, exp_ovf);
    end
    send_byte(8'h0D);
    wait_drain("overflow");
    send_byte("A");
    send_byte(8'h0D);
    wait_drain("overflow_next");
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky got=%b required=1", overflow);
    end
  endtask

  task automatic test_reset_mid_drain;
    int n = 0;
    send_byte("Q");
    send_byte(8'h0D);
    while (strobes < 1 + 0 && n < 0) n++;
    n = 0;
    while (exp_q.size() > (line_q.size() + 8) && n < 0) n++;
    n = 0;
    begin
      int s0 = strobes;
      while (strobes == s0 && n < 200) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (!tx_we && n < 200);
    end
    checks++;
    if (!tx_we) begin
      errors++;
      $display("FAIL mid_drain_second_strobe timeout tx_we got=0 required=1");
    end
    reset = 1'b1;
    #1;
    checks++;
    if (tx_we !== 1'b0 || line_len !== '0) begin
      errors++;
      $display("FAIL reset_abort got we=%b len=%0d required we=0 len=0", tx_we, line_len);
    end
    exp_q.delete();
    line_q.delete();
    exp_ovf = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || tx_we !== 1'b0) begin
      errors++;
      $display("FAIL after_abort got ovf=%b we=%b required 0/0", overflow, tx_we);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backspace;
    test_empty;
    test_drop_busy;
    test_overflow;
    test_reset_mid_drain;
    test_basic;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
